// File: rtl/computer_system_sram_pkg.sv
// Shared types and elaboration helpers for the Computer_System dual-port on-chip SRAM.
package computer_system_sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_t;

    function automatic int be_width(input int dataW);
        return dataW / 8;
    endfunction

    // Only one- and two-stage read pipelines are built.
    function automatic bit read_latency_ok(input int readLatency);
        return (readLatency == 1) || (readLatency == 2);
    endfunction

endpackage

// File: rtl/onchip_sram_bank.sv
// Behavioural true-dual-port byte-enabled RAM with registered reads.
// On a same-address double write, port 1 lanes override port 2 lanes.
module onchip_sram_bank
    import computer_system_sram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [ADDR_W-1:0]             i_addr1,
    input  logic [be_width(DATA_W)-1:0]   i_be1,
    input  logic [DATA_W-1:0]             i_wdata1,
    input  logic                          i_re1,
    output logic [DATA_W-1:0]             o_rdata1,
    input  logic [ADDR_W-1:0]             i_addr2,
    input  logic [be_width(DATA_W)-1:0]   i_be2,
    input  logic [DATA_W-1:0]             i_wdata2,
    input  logic                          i_re2,
    output logic [DATA_W-1:0]             o_rdata2
);

    localparam int BE_W  = be_width(DATA_W);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;

    // Port 2 lanes are assigned first so port 1 wins any shared lane.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (i_be2[b]) r_mem[i_addr2][b*8 +: 8] <= i_wdata2[b*8 +: 8];
            if (i_be1[b]) r_mem[i_addr1][b*8 +: 8] <= i_wdata1[b*8 +: 8];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else begin
            if (i_re1) r_rdata1 <= r_mem[i_addr1];
            if (i_re2) r_rdata2 <= r_mem[i_addr2];
        end
    end

    assign o_rdata1 = r_rdata1;
    assign o_rdata2 = r_rdata2;

endmodule

// File: rtl/computer_system_onchip_sram_dp.sv
// Dual Avalon-MM slave on-chip SRAM with zero-fill after reset and pipelined reads.
// Optional macro ONCHIP_SRAM_RDW_BYPASS_EN returns new data on mixed-port read-during-write.
module computer_system_onchip_sram_dp
    import computer_system_sram_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             address,
    input  logic [be_width(DATA_W)-1:0]   byteenable,
    input  logic                          chipselect,
    input  logic                          read,
    input  logic                          write,
    input  logic [DATA_W-1:0]             writedata,
    output logic [DATA_W-1:0]             readdata,
    output logic                          readdatavalid,
    output logic                          waitrequest,
    input  logic [ADDR_W-1:0]             address2,
    input  logic [be_width(DATA_W)-1:0]   byteenable2,
    input  logic                          chipselect2,
    input  logic                          read2,
    input  logic                          write2,
    input  logic [DATA_W-1:0]             writedata2,
    output logic [DATA_W-1:0]             readdata2,
    output logic                          readdatavalid2,
    output logic                          waitrequest2
);

    localparam int BE_W   = be_width(DATA_W);
    localparam bit LAT_OK = read_latency_ok(READ_LATENCY);

    sram_state_t              r_state;
    sram_state_t              w_nextState;
    logic [ADDR_W-1:0]        r_fillCnt;
    logic                     w_clearing;
    logic                     w_wait;
    logic                     w_wr1Acc, w_rd1Acc, w_wr2Acc, w_rd2Acc;
    logic [ADDR_W-1:0]        w_bankAddr1;
    logic [BE_W-1:0]          w_bankBe1, w_bankBe2;
    logic [DATA_W-1:0]        w_bankWdata1;
    logic [DATA_W-1:0]        w_bankRd1, w_bankRd2;
    logic [DATA_W-1:0]        w_stg1Data1, w_stg1Data2;
    logic [READ_LATENCY-1:0]  r_vld1, r_vld2;

    always_ff @(posedge clk) begin
        assert (LAT_OK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_fillCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == CLEAR) r_fillCnt <= r_fillCnt + 1'b1;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (r_state == CLEAR && r_fillCnt == {ADDR_W{1'b1}}) w_nextState = READY;
    end

    always_comb begin
        w_clearing = (r_state == CLEAR);
        w_wait     = w_clearing;
    end

    assign waitrequest  = w_wait;
    assign waitrequest2 = w_wait;

    // A write on the same port masks the read, so the read never raises a valid.
    assign w_wr1Acc = chipselect  & write  & ~w_wait;
    assign w_rd1Acc = chipselect  & read   & ~write  & ~w_wait;
    assign w_wr2Acc = chipselect2 & write2 & ~w_wait;
    assign w_rd2Acc = chipselect2 & read2  & ~write2 & ~w_wait;

    assign w_bankAddr1  = w_clearing ? r_fillCnt : address;
    assign w_bankBe1    = w_clearing ? {BE_W{1'b1}} : (w_wr1Acc ? byteenable : '0);
    assign w_bankWdata1 = w_clearing ? '0 : writedata;
    assign w_bankBe2    = w_wr2Acc ? byteenable2 : '0;

    onchip_sram_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_addr1  (w_bankAddr1),
        .i_be1    (w_bankBe1),
        .i_wdata1 (w_bankWdata1),
        .i_re1    (w_rd1Acc),
        .o_rdata1 (w_bankRd1),
        .i_addr2  (address2),
        .i_be2    (w_bankBe2),
        .i_wdata2 (writedata2),
        .i_re2    (w_rd2Acc),
        .o_rdata2 (w_bankRd2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld1 <= '0;
            r_vld2 <= '0;
        end else begin
            r_vld1[0] <= w_rd1Acc;
            r_vld2[0] <= w_rd2Acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld1[i] <= r_vld1[i-1];
                r_vld2[i] <= r_vld2[i-1];
            end
        end
    end

`ifdef ONCHIP_SRAM_RDW_BYPASS_EN
    logic              r_byp1En, r_byp2En;
    logic [BE_W-1:0]   r_byp1Be, r_byp2Be;
    logic [DATA_W-1:0] r_byp1Data, r_byp2Data;

    // Capture the other port's write alongside each read so the old word can be patched next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byp1En   <= 1'b0;
            r_byp1Be   <= '0;
            r_byp1Data <= '0;
            r_byp2En   <= 1'b0;
            r_byp2Be   <= '0;
            r_byp2Data <= '0;
        end else begin
            if (w_rd1Acc) begin
                r_byp1En   <= w_wr2Acc && (address2 == address);
                r_byp1Be   <= byteenable2;
                r_byp1Data <= writedata2;
            end
            if (w_rd2Acc) begin
                r_byp2En   <= w_wr1Acc && (address == address2);
                r_byp2Be   <= byteenable;
                r_byp2Data <= writedata;
            end
        end
    end

    always_comb begin
        w_stg1Data1 = w_bankRd1;
        w_stg1Data2 = w_bankRd2;
        for (int b = 0; b < BE_W; b++) begin
            if (r_byp1En && r_byp1Be[b]) w_stg1Data1[b*8 +: 8] = r_byp1Data[b*8 +: 8];
            if (r_byp2En && r_byp2Be[b]) w_stg1Data2[b*8 +: 8] = r_byp2Data[b*8 +: 8];
        end
    end
`else
    assign w_stg1Data1 = w_bankRd1;
    assign w_stg1Data2 = w_bankRd2;
`endif

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign readdata  = w_stg1Data1;
            assign readdata2 = w_stg1Data2;
        end else begin : g_lat2
            logic [DATA_W-1:0] r_readData1, r_readData2;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_readData1 <= '0;
                    r_readData2 <= '0;
                end else begin
                    if (r_vld1[0]) r_readData1 <= w_stg1Data1;
                    if (r_vld2[0]) r_readData2 <= w_stg1Data2;
                end
            end

            assign readdata  = r_readData1;
            assign readdata2 = r_readData2;
        end
    endgenerate

    assign readdatavalid  = r_vld1[READ_LATENCY-1];
    assign readdatavalid2 = r_vld2[READ_LATENCY-1];

endmodule

// File: tb/tb_computer_system_onchip_sram_dp.sv
// Directed self-checking bench: one DUT at READ_LATENCY=1 and one at 2, sharing all inputs.
module tb_computer_system_onchip_sram_dp;

`ifdef ONCHIP_SRAM_RDW_BYPASS_EN
    localparam logic [31:0] RDW1_EXP = 32'hCAFEF00D;
    localparam logic [31:0] RDW2_EXP = 32'h00ADF000;
`else
    localparam logic [31:0] RDW1_EXP = 32'h00000000;
    localparam logic [31:0] RDW2_EXP = 32'h00000000;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  address, address2;
    logic [3:0]  byteenable, byteenable2;
    logic        chipselect, chipselect2;
    logic        read, read2, write, write2;
    logic [31:0] writedata, writedata2;

    logic [31:0] readdataA, readdata2A, readdataB, readdata2B;
    logic        readdatavalidA, readdatavalid2A, readdatavalidB, readdatavalid2B;
    logic        waitrequestA, waitrequest2A, waitrequestB, waitrequest2B;

    int testCount = 0;
    int failCount = 0;
    int fillCycles;
    bit sawValid;

    always #5 clk = ~clk;

    computer_system_onchip_sram_dp #(.DATA_W(32), .ADDR_W(8), .READ_LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata),
        .readdata(readdataA), .readdatavalid(readdatavalidA), .waitrequest(waitrequestA),
        .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
        .read2(read2), .write2(write2), .writedata2(writedata2),
        .readdata2(readdata2A), .readdatavalid2(readdatavalid2A), .waitrequest2(waitrequest2A)
    );

    computer_system_onchip_sram_dp #(.DATA_W(32), .ADDR_W(8), .READ_LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata),
        .readdata(readdataB), .readdatavalid(readdatavalidB), .waitrequest(waitrequestB),
        .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
        .read2(read2), .write2(write2), .writedata2(writedata2),
        .readdata2(readdata2B), .readdatavalid2(readdatavalid2B), .waitrequest2(waitrequest2B)
    );

    function automatic logic [63:0] vd(input logic v, input logic [31:0] d);
        return {31'b0, v, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; byteenable = '0; writedata = '0;
        chipselect2 = 1'b0; read2 = 1'b0; write2 = 1'b0;
        address2 = '0; byteenable2 = '0; writedata2 = '0;
    endtask

    task automatic port1Req(input logic rd, input logic wr, input logic [7:0] a,
                            input logic [3:0] be, input logic [31:0] d);
        chipselect = 1'b1; read = rd; write = wr;
        address = a; byteenable = be; writedata = d;
    endtask

    task automatic port2Req(input logic rd, input logic wr, input logic [7:0] a,
                            input logic [3:0] be, input logic [31:0] d);
        chipselect2 = 1'b1; read2 = rd; write2 = wr;
        address2 = a; byteenable2 = be; writedata2 = d;
    endtask

    // Present the pending requests across one rising edge, then release them.
    task automatic applyStimulus();
        tick();
        idleInputs();
    endtask

    task automatic measureFill(output int cycles, output bit anyValid);
        cycles = 0;
        anyValid = 1'b0;
        while (waitrequestA && cycles < 2000) begin
            if (readdatavalidA | readdatavalid2A | readdatavalidB | readdatavalid2B) anyValid = 1'b1;
            cycles++;
            tick();
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idleInputs();
        repeat (3) tick();
        checkOutput("reset_wait", 64'({waitrequestA, waitrequest2A, waitrequestB, waitrequest2B}), 64'hF);
        checkOutput("reset_valid", 64'({readdatavalidA, readdatavalid2A, readdatavalidB, readdatavalid2B}), 64'h0);
        checkOutput("reset_data", {readdataA | readdata2A, readdataB | readdata2B}, 64'h0);

        reset = 1'b0;
        measureFill(fillCycles, sawValid);
        checkOutput("fill_len", 64'(fillCycles), 64'd256);
        checkOutput("fill_no_valid", 64'(sawValid), 64'd0);
        checkOutput("fill_done_wait", 64'({waitrequestA, waitrequest2A, waitrequestB, waitrequest2B}), 64'h0);

        for (int i = 0; i < 256; i++) begin
            port1Req(1'b1, 1'b0, 8'(i), 4'h0, 32'h0);
            port2Req(1'b1, 1'b0, 8'(255 - i), 4'h0, 32'h0);
            applyStimulus();
            checkOutput("zero_p1_lat1", vd(readdatavalidA, readdataA), vd(1'b1, 32'h0));
            checkOutput("zero_p2_lat1", vd(readdatavalid2A, readdata2A), vd(1'b1, 32'h0));
            if (i > 0) checkOutput("zero_p2_lat2", vd(readdatavalid2B, readdata2B), vd(1'b1, 32'h0));
        end
        applyStimulus();
        checkOutput("zero_tail_lat2", vd(readdatavalidB, readdataB), vd(1'b1, 32'h0));
        applyStimulus();
        checkOutput("idle_valid", 64'({readdatavalidA, readdatavalid2A, readdatavalidB, readdatavalid2B}), 64'h0);

        port1Req(1'b0, 1'b1, 8'd5, 4'hF, 32'hAABBCCDD);
        applyStimulus();
        port2Req(1'b0, 1'b1, 8'd5, 4'h3, 32'h11223344);
        applyStimulus();
        port1Req(1'b1, 1'b0, 8'd5, 4'h0, 32'h0);
        applyStimulus();
        checkOutput("be_merge_lat1", vd(readdatavalidA, readdataA), vd(1'b1, 32'hAABB3344));
        checkOutput("lat2_not_early", 64'(readdatavalidB), 64'd0);
        applyStimulus();
        checkOutput("lat1_hold", vd(readdatavalidA, readdataA), vd(1'b0, 32'hAABB3344));
        checkOutput("be_merge_lat2", vd(readdatavalidB, readdataB), vd(1'b1, 32'hAABB3344));
        applyStimulus();
        checkOutput("lat2_single", 64'(readdatavalidB), 64'd0);

        port2Req(1'b0, 1'b1, 8'd5, 4'h0, 32'h0);
        applyStimulus();
        port2Req(1'b1, 1'b0, 8'd5, 4'h0, 32'h0);
        applyStimulus();
        checkOutput("be_zero_noop", vd(readdatavalid2A, readdata2A), vd(1'b1, 32'hAABB3344));

        port1Req(1'b0, 1'b1, 8'd9, 4'h1, 32'hFFFFFFFF);
        port2Req(1'b0, 1'b1, 8'd9, 4'hF, 32'h12345678);
        applyStimulus();
        port1Req(1'b1, 1'b0, 8'd9, 4'h0, 32'h0);
        port2Req(1'b1, 1'b0, 8'd9, 4'h0, 32'h0);
        applyStimulus();
        checkOutput("collide_p1", vd(readdatavalidA, readdataA), vd(1'b1, 32'h123456FF));
        checkOutput("collide_p2", vd(readdatavalid2A, readdata2A), vd(1'b1, 32'h123456FF));

        port2Req(1'b0, 1'b1, 8'd3, 4'hF, 32'hCAFEF00D);
        port1Req(1'b1, 1'b0, 8'd3, 4'h0, 32'h0);
        applyStimulus();
        checkOutput("rdw_p1_lat1", vd(readdatavalidA, readdataA), vd(1'b1, RDW1_EXP));
        applyStimulus();
        checkOutput("rdw_p1_lat2", vd(readdatavalidB, readdataB), vd(1'b1, RDW1_EXP));
        port1Req(1'b1, 1'b0, 8'd3, 4'h0, 32'h0);
        applyStimulus();
        checkOutput("rdw_after", vd(readdatavalidA, readdataA), vd(1'b1, 32'hCAFEF00D));

        port1Req(1'b0, 1'b1, 8'd20, 4'h6, 32'h0BADF00D);
        port2Req(1'b1, 1'b0, 8'd20, 4'h0, 32'h0);
        applyStimulus();
        checkOutput("rdw_p2_lat1", vd(readdatavalid2A, readdata2A), vd(1'b1, RDW2_EXP));

        port1Req(1'b1, 1'b1, 8'd12, 4'hF, 32'h55AA55AA);
        applyStimulus();
        checkOutput("rw_same_port", 64'(readdatavalidA), 64'd0);
        applyStimulus();
        checkOutput("rw_same_port_lat2", 64'(readdatavalidB), 64'd0);
        port1Req(1'b1, 1'b0, 8'd12, 4'h0, 32'h0);
        applyStimulus();
        checkOutput("rw_write_done", vd(readdatavalidA, readdataA), vd(1'b1, 32'h55AA55AA));

        for (int i = 0; i < 8; i++) begin
            port1Req(1'b0, 1'b1, 8'(i), 4'hF, 32'hA0000000 | 32'(i));
            applyStimulus();
        end
        for (int k = 0; k < 10; k++) begin
            if (k < 8) port2Req(1'b1, 1'b0, 8'(k), 4'h0, 32'h0);
            applyStimulus();
            if (k < 8) checkOutput("burst_lat1", vd(readdatavalid2A, readdata2A), vd(1'b1, 32'hA0000000 | 32'(k)));
            if (k == 0) checkOutput("burst_lat2_first", 64'(readdatavalid2B), 64'd0);
            else if (k < 9) checkOutput("burst_lat2", vd(readdatavalid2B, readdata2B), vd(1'b1, 32'hA0000000 | 32'(k - 1)));
            else checkOutput("burst_lat2_end", vd(readdatavalid2B, readdata2B), vd(1'b0, 32'hA0000007));
        end

        port1Req(1'b0, 1'b1, 8'd4, 4'hF, 32'hDEADBEEF);
        port2Req(1'b0, 1'b1, 8'd200, 4'hF, 32'hFEEDFACE);
        applyStimulus();
        port1Req(1'b1, 1'b0, 8'd4, 4'h0, 32'h0);
        tick();
        idleInputs();
        reset = 1'b1;
        #1;
        checkOutput("inflight_drop", 64'({readdatavalidB, waitrequestA}), 64'h1);
        tick();
        reset = 1'b0;
        repeat (100) tick();
        checkOutput("midfill_wait", 64'({waitrequestA, waitrequestB}), 64'h3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        port1Req(1'b1, 1'b0, 8'd4, 4'h0, 32'h0);
        port2Req(1'b1, 1'b0, 8'd200, 4'h0, 32'h0);
        measureFill(fillCycles, sawValid);
        checkOutput("refill_len", 64'(fillCycles), 64'd256);
        checkOutput("refill_no_valid", 64'(sawValid), 64'd0);
        applyStimulus();
        checkOutput("stalled_p1", vd(readdatavalidA, readdataA), vd(1'b1, 32'h0));
        checkOutput("stalled_p2", vd(readdatavalid2A, readdata2A), vd(1'b1, 32'h0));
        applyStimulus();
        checkOutput("stalled_p2_lat2", vd(readdatavalid2B, readdata2B), vd(1'b1, 32'h0));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/computer_system_onchip_sram_dp.md
# computer_system_onchip_sram_dp

Parametrised true-dual-port on-chip SRAM for the Computer_System fabric, exposing two Avalon-MM slaves (s1, s2) on a single clock. It is the successor to the fixed 256x32 dual-port SRAM. Beyond that block, it adds:
- configurable width, depth and read latency;
- explicit `readdatavalid` and `waitrequest`;
- a hardware zero-fill after reset;
- deterministic same-address collision rules.

Typical users are the HPS bridge on s1 and the pixel/VGA master on s2.

## Interface
- DATA_W, 32, data width per port; must be a multiple of 8.
- ADDR_W, 8, word-address width; DEPTH = 2**ADDR_W words.
- READ_LATENCY, 1, cycles from accepted read to `readdatavalid`; legal values 1 or 2.
- clk  in  1  sole clock for both ports.
- reset  in  1  asynchronous, active-high reset.
- address / address2  in  ADDR_W  word address, s1 / s2.
- byteenable / byteenable2  in  DATA_W/8  byte-lane enables.
- chipselect / chipselect2  in  1  port select.
- read / read2  in  1  read request.
- write / write2  in  1  write request.
- writedata / writedata2  in  DATA_W  write data.
- readdata / readdata2  out  DATA_W  read data; valid only when `readdatavalid` is high.
- readdatavalid / readdatavalid2  out  1  read data strobe.
- waitrequest / waitrequest2  out  1  high while zero-fill is running.

## Operation
- Reset values:
  - readdata/readdata2 = 0.
  - readdatavalid/readdatavalid2 = 0.
  - waitrequest/waitrequest2 = 1.
  - FSM = CLEAR, fill counter = 0.
- FSM states: CLEAR and READY.
  - CLEAR: writes 0 to the word at the fill counter every cycle, with all byte lanes enabled; the counter increments each cycle.
  - CLEAR -> READY when the counter reaches DEPTH-1, after that final write.
  - READY is held until the next reset.
- Reset asserted at any time, including mid-CLEAR: returns to CLEAR with the counter at 0. In-flight reads are discarded and no `readdatavalid` is produced for them.
- Transaction acceptance:
  - A write is accepted when `chipselect & write & ~waitrequest`.
  - A read is accepted when `chipselect & read & ~waitrequest`.
  - Requests presented during CLEAR are stalled, not dropped; the master holds them.
- `read` and `write` both high on one port: the write is performed and the read is ignored (no `readdatavalid`).
- Writes update only the byte lanes whose `byteenable` bit is 1. A write with byteenable = 0 is a no-op.
- Both ports write the same address in the same cycle:
  - s1 wins on overlapping lanes.
  - Non-overlapping s2 lanes are written.
- A port reading an address it is not writing that cycle returns the stored data.
- Mixed-port read-during-write (one port reads the address the other port writes in that cycle): result depends on the macro; see Configuration.
- Out-of-range addresses cannot occur, because depth is exactly 2**ADDR_W.

## Timing
- Fill time: CLEAR lasts DEPTH cycles after reset deasserts. `waitrequest` falls on the clock edge after the last fill write, so the first transaction can be accepted in cycle DEPTH.
- Write latency is 0: the write commits at the accepting edge, and a read accepted on the next cycle returns the new data.
- Read latency:
  - A read accepted in cycle N gives `readdatavalid`=1 and valid `readdata` in cycle N+READ_LATENCY, for exactly one cycle.
  - Back-to-back reads are accepted every cycle, giving a fully pipelined one-word-per-cycle throughput per port.
- `readdata` holds its last value when `readdatavalid`=0.
- The two ports are independent; neither ever stalls the other while in READY.

## Configuration
- Macro `ONCHIP_SRAM_RDW_BYPASS_EN`.
- Defined: a mixed-port read-during-write returns the new data. This is a merge of the writer's data on its enabled lanes with the old data on the other lanes, implemented by a bypass mux in the read pipeline.
- Undefined: a mixed-port read-during-write returns the old data, with no bypass logic.
- Same-port behaviour is identical in both builds.

## Structure
- Package `computer_system_sram_pkg` holds:
  - the `sram_state_t` enum (CLEAR, READY);
  - a `be_width(DATA_W)` constant function;
  - the READ_LATENCY legality check.
- Sub-module `onchip_sram_bank`: a behavioural true-dual-port byte-enabled RAM array, with synchronous reads and s1-priority write resolution.
- The top level contains:
  - the CLEAR/READY FSM and fill counter;
  - the acceptance logic;
  - the read-valid shift pipeline (depth READ_LATENCY);
  - the optional bypass mux.

## Test plan
- Reset release with DEPTH=256: `waitrequest` is 1 for 256 cycles and then 0. A read of every address on both ports returns 0.
- Reset pulsed at fill cycle 100: the fill restarts and `waitrequest` stays high for a further 256 cycles from reset release.
- s1 writes 0xAABBCCDD to address 5 with byteenable=0xF, then s2 writes 0x11223344 to address 5 with byteenable=0x3. An s1 read at N gives `readdatavalid` at N+READ_LATENCY with `readdata`=0xAABB3344.
- Same cycle: s1 writes 0xFFFFFFFF with byteenable=0x1 and s2 writes 0x12345678 with byteenable=0xF, both to address 9. A subsequent read returns 0x123456FF.
- Old contents 0x0; s2 writes 0xCAFEF00D to address 3 in the same cycle that s1 reads address 3:
  - with the macro, s1 gets 0xCAFEF00D;
  - without it, s1 gets 0x00000000.
- READ_LATENCY=2, s2 reads addresses 0..7 back-to-back: `readdatavalid2` is high for 8 consecutive cycles starting 2 cycles after the first accept, with the data in address order.
